pll_drp_master: RTL and testbench

- DRP initiator that drives the dynamic reconfiguration port of the PLL/MMCM wrappers (DADDR/DEN/DI/DWE out, DO/DRDY in).
- Accepts read, write and read-modify-write commands over a valid/ready command channel.
- Returns read data and error status over a valid/ready response channel.
- Sits between the SoC-side CSR/reconfig logic and the PLL wrapper's DRP pins, in the DCLK domain.

---
 rtl/pll_drp_pkg.sv | 25 ++
 rtl/drp_timeout_ctr.sv | 38 +++
 rtl/pll_drp_master.sv | 217 +++++++++++++++++++++
 tb/tb_pll_drp_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types and default widths for the PLL/MMCM DRP initiator.
package pll_drp_pkg;

    localparam int unsigned DRP_ADDR_W         = 7;
    localparam int unsigned DRP_DATA_W         = 16;
    localparam int unsigned DRP_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_RMW  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_MODIFY   = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_WAIT  = 3'd5,
        ST_RESP     = 3'd6
    } state_e;

endpackage

// File: rtl/drp_timeout_ctr.sv
// DRDY wait-budget counter: cleared before each wait, counts enabled cycles,
// flags the cycle in which the TIMEOUT_CYCLES-th enabled cycle elapses.
module drp_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires while the last allowed empty wait cycle is in progress.
    assign expired = enable && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pll_drp_master.sv
// DRP initiator for PLL/MMCM wrappers: read, write and read-modify-write commands.
// Optional macro PLL_DRP_LOCK_GATE_EN adds LOCKED gating and an rst_pll hold output.
module pll_drp_master
    import pll_drp_pkg::*;
#(
    parameter int unsigned ADDR_W         = DRP_ADDR_W,
    parameter int unsigned DATA_W         = DRP_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DRP_TIMEOUT_CYCLES
) (
    input  logic              DCLK,
    input  logic              RST,
`ifdef PLL_DRP_LOCK_GATE_EN
    input  logic              LOCKED,
    output logic              rst_pll,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] DADDR,
    output logic              DEN,
    output logic [DATA_W-1:0] DI,
    output logic              DWE,
    input  logic [DATA_W-1:0] DO,
    input  logic              DRDY
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   di_q, di_d;
    logic                den_q, den_d;
    logic                dwe_q, dwe_d;
    logic                drdy_prev_q, drdy_prev_d;
`ifdef PLL_DRP_LOCK_GATE_EN
    logic                rst_pll_q, rst_pll_d;
`endif

    logic cmd_fire_c;
    logic resp_fire_c;
    logic drdy_ok_c;
    logic in_wait_c;
    logic tmo_clear_c;
    logic tmo_expired_c;

    assign cmd_fire_c  = cmd_valid && cmd_ready_q;
    assign resp_fire_c = (state_q == ST_RESP) && resp_ready;
    // A DRDY held high across cycles is credited only on its rising edge.
    assign drdy_ok_c   = DRDY && !drdy_prev_q;
    assign in_wait_c   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign tmo_clear_c = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);

    drp_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (DCLK),
        .rst    (RST),
        .clear  (tmo_clear_c),
        .enable (in_wait_c && !drdy_ok_c),
        .expired(tmo_expired_c)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        drdy_prev_d = DRDY;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    op_d    = op_e'(cmd_op);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    mask_d  = cmd_mask;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    case (op_e'(cmd_op))
                        OP_RD, OP_RMW: state_d = ST_RD_ISSUE;
                        OP_WR:         state_d = ST_WR_ISSUE;
                        default: begin
                            state_d = ST_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (drdy_ok_c) begin
                    rdata_d = DO;
                    state_d = (op_q == OP_RMW) ? ST_MODIFY : ST_RESP;
                end else if (tmo_expired_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_MODIFY: begin
                wdata_d = (rdata_q & mask_q) | (wdata_q & ~mask_q);
                state_d = ST_WR_ISSUE;
            end
            ST_WR_ISSUE: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (drdy_ok_c) begin
                    state_d = ST_RESP;
                end else if (tmo_expired_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // DRP pins are registered from the state being entered, so DEN
        // lines up with the ISSUE cycle and lasts exactly one cycle.
        den_d        = (state_d == ST_RD_ISSUE) || (state_d == ST_WR_ISSUE);
        dwe_d        = (state_d == ST_WR_ISSUE);
        daddr_d      = den_d ? addr_d : daddr_q;
        di_d         = dwe_d ? wdata_d : di_q;
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
`ifdef PLL_DRP_LOCK_GATE_EN
        cmd_ready_d  = (state_d == ST_IDLE) && LOCKED;
        rst_pll_d    = rst_pll_q;
        if (cmd_fire_c && ((op_e'(cmd_op) == OP_WR) || (op_e'(cmd_op) == OP_RMW))) begin
            rst_pll_d = 1'b1;
        end else if (resp_fire_c) begin
            rst_pll_d = 1'b0;
        end
`else
        cmd_ready_d  = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge DCLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            daddr_q      <= '0;
            di_q         <= '0;
            den_q        <= 1'b0;
            dwe_q        <= 1'b0;
            drdy_prev_q  <= 1'b0;
`ifdef PLL_DRP_LOCK_GATE_EN
            rst_pll_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            daddr_q      <= daddr_d;
            di_q         <= di_d;
            den_q        <= den_d;
            dwe_q        <= dwe_d;
            drdy_prev_q  <= drdy_prev_d;
`ifdef PLL_DRP_LOCK_GATE_EN
            rst_pll_q    <= rst_pll_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
    assign DADDR      = daddr_q;
    assign DI         = di_q;
    assign DEN        = den_q;
    assign DWE        = dwe_q;
`ifdef PLL_DRP_LOCK_GATE_EN
    assign rst_pll    = rst_pll_q;
`endif

endmodule

// File: tb/tb_pll_drp_master.sv
// Randomized bench for pll_drp_master: behavioural PLL register model plus a DRP responder.
module tb_pll_drp_master;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 64;

    logic          DCLK = 1'b0;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_mask;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          busy;
    logic [AW-1:0] DADDR;
    logic          DEN;
    logic [DW-1:0] DI;
    logic          DWE;
    logic [DW-1:0] DO;
    logic          DRDY;

    always #5 DCLK = ~DCLK;

    pll_drp_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .DCLK(DCLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .DADDR(DADDR), .DEN(DEN), .DI(DI), .DWE(DWE), .DO(DO), .DRDY(DRDY)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] di;
    } acc_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] ref_mem  [128];
    logic [DW-1:0] phys_mem [128];
    acc_t          log_q[$];
    int            rsp_lat  = 1;
    bit            rsp_mute = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic acc_t mk_acc(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
        acc_t r;
        r.addr = a;
        r.we   = we;
        r.di   = d;
        return r;
    endfunction

    // PLL-side responder: answers each DEN after rsp_lat cycles unless muted.
    initial begin
        int            pend = 0;
        logic [DW-1:0] pend_do = '0;
        logic          den_prev = 1'b0;
        DRDY = 1'b0;
        DO   = '0;
        forever begin
            @(posedge DCLK);
            #1;
            DRDY = 1'b0;
            DO   = DW'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    DRDY = 1'b1;
                    DO   = pend_do;
                end
            end
            if (DWE) check("dwe_needs_den", 32'(DEN), 32'd1);
            if (DEN) begin
                check("den_single_cycle", 32'(den_prev), 32'd0);
                log_q.push_back(mk_acc(DADDR, DWE, DWE ? DI : '0));
                if (DWE) phys_mem[DADDR] = DI;
                else     pend_do = phys_mem[DADDR];
                if (!rsp_mute) pend = rsp_lat;
            end
            den_prev = DEN;
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] mask,
                           input int lat, input bit mute, input int rdly);
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            exp_cyc;
        acc_t          exp_q[$];
        int            cyc;
        int            w;
        bit            chk_rd;

        old     = ref_mem[addr];
        nw      = (old & mask) | (wd & ~mask);
        exp_rd  = '0;
        exp_err = 1'b0;
        exp_cyc = 1;
        chk_rd  = 1'b1;
        case (op)
            2'd0: begin
                exp_q.push_back(mk_acc(addr, 1'b0, '0));
                if (mute) begin exp_err = 1'b1; exp_cyc = 2 + TO; end
                else      begin exp_rd = old;   exp_cyc = 2 + lat; end
            end
            2'd1: begin
                exp_q.push_back(mk_acc(addr, 1'b1, wd));
                ref_mem[addr] = wd;
                exp_err = mute;
                exp_cyc = mute ? 2 + TO : 2 + lat;
                chk_rd  = mute;
            end
            2'd2: begin
                exp_q.push_back(mk_acc(addr, 1'b0, '0));
                if (mute) begin
                    exp_err = 1'b1;
                    exp_cyc = 2 + TO;
                end else begin
                    exp_q.push_back(mk_acc(addr, 1'b1, nw));
                    ref_mem[addr] = nw;
                    exp_rd  = old;
                    exp_cyc = 4 + 2 * lat;
                end
            end
            default: begin
                exp_err = 1'b1;
                exp_cyc = 1;
            end
        endcase

        rsp_lat  = lat;
        rsp_mute = mute;
        log_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_mask  = mask;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge DCLK); #1; w++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge DCLK); #1;
        cmd_valid = 1'b0;
        cmd_wdata = DW'($urandom);
        cmd_mask  = DW'($urandom);
        if (exp_cyc > 1) begin
            check("busy_after_accept", 32'(busy), 32'd1);
            check("ready_after_accept", 32'(cmd_ready), 32'd0);
        end
        cyc = 1;
        while (!resp_valid && cyc < 300) begin
            @(posedge DCLK); #1; cyc++;
        end
        check("resp_latency", 32'(cyc), 32'(exp_cyc));
        if (!resp_valid) return;
        for (int i = 0; i < rdly; i++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_err", 32'(resp_err), 32'(exp_err));
            if (chk_rd) check("hold_rdata", 32'(resp_rdata), 32'(exp_rd));
            @(posedge DCLK); #1;
        end
        check("resp_err", 32'(resp_err), 32'(exp_err));
        if (chk_rd) check("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
        resp_ready = 1'b1;
        @(posedge DCLK); #1;
        resp_ready = 1'b0;
        check("resp_valid_drop", 32'(resp_valid), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("access_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("access_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            check("access_we", 32'(log_q[i].we), 32'(exp_q[i].we));
            check("access_di", 32'(log_q[i].di), 32'(exp_q[i].di));
        end
    endtask

    task automatic reset_mid_read();
        rsp_lat  = 4;
        rsp_mute = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_addr  = AW'(3);
        @(posedge DCLK); #1;
        cmd_valid = 1'b0;
        check("rst_test_den", 32'(DEN), 32'd1);
        @(posedge DCLK); #1;
        RST = 1'b1;
        @(posedge DCLK); #1;
        RST = 1'b0;
        check("rst_den", 32'(DEN), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_daddr", 32'(DADDR), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge DCLK); #1;
            check("late_drdy_no_resp", 32'(resp_valid), 32'd0);
            check("late_drdy_idle", 32'(busy), 32'd0);
        end
        log_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        RST        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_mask   = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i]  = DW'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[0] = 16'h1234; phys_mem[0] = 16'h1234;
        ref_mem[3] = 16'hDEF0; phys_mem[3] = 16'hDEF0;
        ref_mem[1] = 16'h5678; phys_mem[1] = 16'h5678;

        repeat (3) @(posedge DCLK);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_den_dwe", 32'({DEN, DWE}), 32'd0);
        check("rst_daddr_di", 32'({DADDR, DI}), 32'd0);
        RST = 1'b0;
        @(posedge DCLK); #1;

        run_cmd(2'd0, AW'(0), 16'h0000, 16'h0000, 1, 1'b0, 0);
        run_cmd(2'd0, AW'(3), 16'h0000, 16'h0000, 1, 1'b0, 0);
        run_cmd(2'd1, AW'(5), 16'hA5A5, 16'h0000, 1, 1'b0, 0);
        run_cmd(2'd2, AW'(1), 16'h00AA, 16'hFF00, 1, 1'b0, 0);
        run_cmd(2'd0, AW'(1), 16'h0000, 16'h0000, 2, 1'b0, 5);
        run_cmd(2'd0, AW'(7), 16'h0000, 16'h0000, 1, 1'b1, 0);
        run_cmd(2'd2, AW'(9), 16'h1111, 16'h00FF, 1, 1'b1, 0);
        run_cmd(2'd1, AW'(11), 16'hBEEF, 16'h0000, 1, 1'b1, 1);
        run_cmd(2'd3, AW'(2), 16'hFFFF, 16'h0000, 1, 1'b0, 5);
        reset_mid_read();

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_cmd(op, AW'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(1, 4)), ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge DCLK);
            #0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
